md_ctrl: RTL
============

# md_ctrl

Multiply/divide sequencer for the pipelined core's E stage. It owns the HI/LO registers and latches operands on a one-cycle `start` pulse. It models the fixed multi-cycle latency of MULT/DIV with a countdown and drives `busy`, which the hazard unit ORs into the PC/IF-ID freeze. MFHI/MFLO reads and MTHI/MTLO writes also go through this block, so HI/LO have a single owner.

## Interface
- `MULT_CYCLES`, default 5: busy cycles for MULT/MULTU (legal range 1–31).
- `DIV_CYCLES`, default 10: busy cycles for DIV/DIVU (legal range 1–31).
- `clk` input, 1 bit: single clock, rising edge.
- `reset` input, 1 bit: asynchronous, active-low; 0 clears all state immediately.
- `start` input, 1 bit: E-stage op valid, one cycle per instruction.
- `md_op` input, 3 bits: operation code, encoded in `md_pkg` (MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI, MFLO).
- `rs_val` input, 32 bits: first operand; it is also the MTHI/MTLO data.
- `rt_val` input, 32 bits: second operand.
- `busy` output, 1 bit: a multi-cycle operation is in flight.
- `md_hazard` output, 1 bit: combinational, `busy | (start & md_op is MULT/MULTU/DIV/DIVU)`. It feeds the hazard unit.
- `hi` output, 32 bits: architectural HI.
- `lo` output, 32 bits: architectural LO.
- `md_rd` output, 32 bits: combinational read data. It is HI for MFHI, LO for MFLO, and 0 otherwise.

## Operation
- Two states:
  - IDLE: `busy`=0.
  - RUN: `busy`=1, a 5-bit counter `cnt` is active, and pending result registers `p_hi`/`p_lo` hold the computed result.
- Transitions out of IDLE when `start`=1:
  - MULT/MULTU/DIV/DIVU: compute the result from `rs_val`/`rt_val` at the same edge, store it in `p_hi`/`p_lo`, load `cnt` with MULT_CYCLES or DIV_CYCLES, and go to RUN.
  - MTHI/MTLO: write `rs_val` into HI/LO at that edge and stay in IDLE.
  - MFHI/MFLO: no state change; `md_rd` is valid in the same cycle.
- RUN behaviour: `cnt` decrements each cycle. On the edge where `cnt`==1, copy `p_hi`/`p_lo` into `hi`/`lo` and go to IDLE.
- `start` while in RUN is a protocol violation (the hazard unit prevents it). The block ignores it: no state change and no HI/LO write.
- MFHI/MFLO while in RUN return the old (committed) HI/LO. They are never forwarded from the pending result.
- Arithmetic:
  - MULT: signed 32×32 → 64 product; HI = upper 32 bits, LO = lower 32 bits.
  - MULTU: as MULT, unsigned.
  - DIV: signed; LO = quotient truncated toward zero, HI = remainder with the sign of the dividend.
  - DIVU: unsigned; LO = quotient, HI = remainder.
  - Divide by zero: LO = 32'hFFFF_FFFF, HI = `rs_val`.
  - DIV of 32'h8000_0000 by 32'hFFFF_FFFF: LO = 32'h8000_0000, HI = 0.

## Timing
- Reset values: `hi`=0, `lo`=0, `busy`=0, state IDLE, `cnt`=0, `p_hi`/`p_lo`=0. `md_rd`=0 and `md_hazard`=0 while `start`=0.
- `start` of MULT at edge T0:
  - `busy`=1 from T0 through the edge T0+MULT_CYCLES.
  - HI/LO update at edge T0+MULT_CYCLES, and `busy` falls at that same edge.
  - Total PC freeze = `start` cycle + MULT_CYCLES cycles.
  - DIV follows the same pattern with DIV_CYCLES.
- A back-to-back `start` is accepted on the first cycle where `busy`=0 (zero bubble after completion).
- MTHI/MTLO: the new value is visible on `hi`/`lo` one cycle after `start`.
- Reset asserted during RUN: abort immediately. Pending results are discarded, HI/LO are cleared, and `busy` drops asynchronously.

## Structure
- `md_pkg` holds:
  - the `md_op` encoding constants;
  - default MULT_CYCLES/DIV_CYCLES values;
  - the state encoding (IDLE, RUN).
- One sub-module, `md_arith`: purely combinational. Inputs are `md_op`, `rs_val`, `rt_val`; outputs are 64-bit {hi, lo}. It contains all sign, divide-by-zero and overflow rules.
- `md_ctrl` contains the FSM, the counter, the pending registers, HI/LO and the read mux.

## Test plan
- **Reset:** drive `reset`=0 mid-RUN of a DIV → `busy`=0 at once; `hi`=`lo`=0; no later write when `reset` returns to 1.
- **MULT signed:** MULT with `rs_val`=32'hFFFF_FFFE (−2), `rt_val`=3 → `busy` high for 5 cycles; then `hi`=32'hFFFF_FFFF, `lo`=32'hFFFF_FFFA. MFHI during `busy` returns the old HI.
- **DIV:**
  - DIV with `rs_val`=−7, `rt_val`=2 → after 10 cycles `lo`=32'hFFFF_FFFD (−3), `hi`=32'hFFFF_FFFF (−1).
  - DIVU with `rs_val`=32'hFFFF_FFF9, `rt_val`=2 → `lo`=32'h7FFF_FFFC, `hi`=1.
- **Corner cases:**
  - DIVU of 5 by 0 → `lo`=32'hFFFF_FFFF, `hi`=5.
  - DIV of 32'h8000_0000 by −1 → `lo`=32'h8000_0000, `hi`=0.
- **Handshake:**
  - `start` MULT, then a second `start` DIV injected during RUN → ignored; only the MULT result commits.
  - MULT completes, then DIV is issued on the next cycle → accepted with no idle gap.
  - MTLO 32'h1234_5678 → `lo` updates next cycle and `busy` stays 0.

Source files
------------

// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide sequencer: op encoding, default
// latencies and FSM state encoding.
package md_pkg;

   localparam int unsigned MD_OP_W  = 3;
   localparam int unsigned MD_CNT_W = 5;

   localparam int unsigned MD_MULT_CYCLES_DEF = 5;
   localparam int unsigned MD_DIV_CYCLES_DEF  = 10;

   typedef enum logic [MD_OP_W-1:0] {
      OP_MULT  = 3'd0,
      OP_MULTU = 3'd1,
      OP_DIV   = 3'd2,
      OP_DIVU  = 3'd3,
      OP_MTHI  = 3'd4,
      OP_MTLO  = 3'd5,
      OP_MFHI  = 3'd6,
      OP_MFLO  = 3'd7
   } md_op_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } md_state_e;

   // True for the ops that occupy the unit for several cycles.
   function automatic logic md_is_long(input logic [MD_OP_W-1:0] op);
      return (op == OP_MULT) || (op == OP_MULTU) ||
             (op == OP_DIV)  || (op == OP_DIVU);
   endfunction

endpackage

// File: rtl/md_ctrl_if.sv
// E-stage <-> multiply/divide unit signal bundle.
interface md_ctrl_if;
   import md_pkg::*;

   logic                start;
   logic [MD_OP_W-1:0]  md_op;
   logic [31:0]         rs_val;
   logic [31:0]         rt_val;
   logic                busy;
   logic                md_hazard;
   logic [31:0]         hi;
   logic [31:0]         lo;
   logic [31:0]         md_rd;

   modport master (
      output start, md_op, rs_val, rt_val,
      input  busy, md_hazard, hi, lo, md_rd
   );

   modport slave (
      input  start, md_op, rs_val, rt_val,
      output busy, md_hazard, hi, lo, md_rd
   );

endinterface

// File: rtl/md_arith.sv
// Combinational MULT/MULTU/DIV/DIVU datapath producing {hi, lo}, including
// the divide-by-zero and signed-overflow results.
module md_arith
   import md_pkg::*;
(
   input  logic [MD_OP_W-1:0] md_op,
   input  logic [31:0]        rs_val,
   input  logic [31:0]        rt_val,
   output logic [63:0]        result
);

   logic signed [63:0] prod_s;
   logic        [63:0] prod_u;
   logic               div_zero;
   logic               div_ovf;
   logic        [31:0] rt_safe;
   logic signed [31:0] quo_s;
   logic signed [31:0] rem_s;
   logic        [31:0] quo_u;
   logic        [31:0] rem_u;

   assign prod_s = $signed({{32{rs_val[31]}}, rs_val}) * $signed({{32{rt_val[31]}}, rt_val});
   assign prod_u = {32'h0, rs_val} * {32'h0, rt_val};

   assign div_zero = (rt_val == 32'h0);
   assign div_ovf  = (rs_val == 32'h8000_0000) && (rt_val == 32'hFFFF_FFFF);

   // The divider never sees a zero or overflowing divisor; those cases are
   // overridden below, so a harmless divisor of 1 is substituted.
   assign rt_safe = (div_zero || div_ovf) ? 32'd1 : rt_val;

   assign quo_s = $signed(rs_val) / $signed(rt_safe);
   assign rem_s = $signed(rs_val) % $signed(rt_safe);
   assign quo_u = rs_val / rt_safe;
   assign rem_u = rs_val % rt_safe;

   always_comb begin
      result = '0;
      case (md_op_e'(md_op))
         OP_MULT:  result = prod_s;
         OP_MULTU: result = prod_u;
         OP_DIV: begin
            if (div_zero)     result = {rs_val, 32'hFFFF_FFFF};
            else if (div_ovf) result = {32'h0, 32'h8000_0000};
            else              result = {rem_s, quo_s};
         end
         OP_DIVU: begin
            if (div_zero) result = {rs_val, 32'hFFFF_FFFF};
            else          result = {rem_u, quo_u};
         end
         default:  result = '0;
      endcase
   end

endmodule

// File: rtl/md_ctrl.sv
// Multiply/divide sequencer: owns HI/LO, models MULT/DIV latency with a
// countdown and raises busy for the pipeline freeze.
module md_ctrl
   import md_pkg::*;
#(
   parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES_DEF,
   parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES_DEF
)
(
   input  logic        clk,
   input  logic        reset,
   md_ctrl_if.slave    bus
);

   localparam logic [MD_CNT_W-1:0] MULT_LAT = MD_CNT_W'(MULT_CYCLES);
   localparam logic [MD_CNT_W-1:0] DIV_LAT  = MD_CNT_W'(DIV_CYCLES);

   md_state_e           state, state_nxt;
   logic [MD_CNT_W-1:0] cnt, cnt_nxt;
   logic [31:0]         p_hi, p_hi_nxt;
   logic [31:0]         p_lo, p_lo_nxt;
   logic [31:0]         hi_q, hi_nxt;
   logic [31:0]         lo_q, lo_nxt;
   logic [63:0]         arith_res;

   md_arith u_arith (
      .md_op  (bus.md_op),
      .rs_val (bus.rs_val),
      .rt_val (bus.rt_val),
      .result (arith_res)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ST_IDLE;
         cnt   <= '0;
         p_hi  <= '0;
         p_lo  <= '0;
         hi_q  <= '0;
         lo_q  <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         p_hi  <= p_hi_nxt;
         p_lo  <= p_lo_nxt;
         hi_q  <= hi_nxt;
         lo_q  <= lo_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      p_hi_nxt  = p_hi;
      p_lo_nxt  = p_lo;
      hi_nxt    = hi_q;
      lo_nxt    = lo_q;
      case (state)
         ST_IDLE: begin
            if (bus.start) begin
               case (md_op_e'(bus.md_op))
                  OP_MULT, OP_MULTU: begin
                     p_hi_nxt  = arith_res[63:32];
                     p_lo_nxt  = arith_res[31:0];
                     cnt_nxt   = MULT_LAT;
                     state_nxt = ST_RUN;
                  end
                  OP_DIV, OP_DIVU: begin
                     p_hi_nxt  = arith_res[63:32];
                     p_lo_nxt  = arith_res[31:0];
                     cnt_nxt   = DIV_LAT;
                     state_nxt = ST_RUN;
                  end
                  OP_MTHI: hi_nxt = bus.rs_val;
                  OP_MTLO: lo_nxt = bus.rs_val;
                  default: ;
               endcase
            end
         end
         ST_RUN: begin
            // start is ignored here; the hazard unit keeps it from arriving.
            cnt_nxt = cnt - MD_CNT_W'(1);
            if (cnt == MD_CNT_W'(1)) begin
               hi_nxt    = p_hi;
               lo_nxt    = p_lo;
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign bus.busy      = (state == ST_RUN);
   assign bus.md_hazard = bus.busy | (bus.start & md_is_long(bus.md_op));
   assign bus.hi        = hi_q;
   assign bus.lo        = lo_q;

   // Reads always return committed HI/LO, never the pending result.
   always_comb begin
      bus.md_rd = '0;
      if (bus.start) begin
         if (bus.md_op == OP_MFHI)      bus.md_rd = hi_q;
         else if (bus.md_op == OP_MFLO) bus.md_rd = lo_q;
      end
   end

endmodule
